load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the control decoder.
- Consumes the decoder's load_or_store flag together with funct3 and the ALU-computed address.
- Runs one data-memory transaction through a req/ack handshake and stalls the pipeline until it completes.
- Returns sign- or zero-extended load data, and reports misaligned, illegal-funct3 and timeout faults.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 255, maximum ACCESS cycles without mem_ack before a timeout fault (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ls_valid  input  1  load/store pending (decoder load_or_store qualified by instruction valid); held until done or fault.
- ls_store  input  1  1 = store, 0 = load (opcode bit 5).
- ls_funct3  input  3  access size/sign.
- ls_addr  input  XLEN  byte address.
- ls_wdata  input  XLEN  store data (rs2).
- stall  output  1  freeze upstream stages.
- done  output  1  one-cycle pulse: access complete.
- load_data  output  XLEN  extended load result, valid while done=1.
- fault  output  1  one-cycle pulse: access aborted.
- fault_cause  output  2  01 misaligned, 10 illegal funct3, 11 timeout; valid while fault=1.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable.
- mem_addr  output  XLEN  word-aligned address, {ls_addr[XLEN-1:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  XLEN  lane-replicated store data.
- mem_ack  input  1  memory completes the request this cycle; rdata valid in the same cycle.
- mem_rdata  input  XLEN  read word.

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0. All outputs 0: stall, done, fault, fault_cause, mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data.
- FSM states: IDLE, ACCESS, DONE, FAULT.
- IDLE with ls_valid=1:
  - Check legality, then register addr, we, be, wdata and funct3.
  - Legal: go to ACCESS.
  - Illegal: latch cause, go to FAULT.
- Legal funct3:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other value is illegal (cause 10).
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0 (cause 01). If funct3 is illegal, cause 10 takes priority.
- ACCESS:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are driven from the captured registers and held stable until ack.
  - mem_ack=1: capture the extended load data, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ack, go to FAULT with cause 11.
  - The counter clears on leaving ACCESS.
- DONE: done=1 for one cycle, load_data valid; return to IDLE. ls_valid is ignored in this state.
- FAULT: fault=1 and fault_cause valid for one cycle; return to IDLE. ls_valid is ignored; no memory request is issued.
- stall = (state==IDLE & ls_valid) | state==ACCESS. It deasserts in the DONE/FAULT cycle so the pipeline advances.
- Latency: accept at cycle N, mem_req at N+1, ack at N+1 at the earliest, done at N+2.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << addr[1:0].
  - SW: 4'b1111.
- Store data: SB replicates the byte into all 4 lanes; SH replicates the halfword into 2 lanes; SW passes through.
- Load extraction: select the byte or half by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- mem_ack outside ACCESS is ignored.
- Reset asserted mid-ACCESS drops mem_req immediately (async); no done or fault is emitted.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW).
  - State enum lsu_state_t {IDLE, ACCESS, DONE, FAULT}.
  - Fault-cause constants CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_TIMEOUT.
- Sub-module lsu_align: purely combinational. Covers the legality/misalignment check, byte-enable and store-lane generation, and load extraction and extension.
- load_store_unit holds the FSM, the capture registers and the timeout counter.

Test Plan:
- LW, addr 0x1000, mem_rdata 0xDEADBEEF, ack one cycle after req:
  - mem_be=1111, mem_addr=0x1000.
  - done at cycle N+3, load_data=0xDEADBEEF.
  - stall high from N until the done cycle.
- LB at 0x1003 with rdata 0x80FFFFFF → be=1000, load_data=0xFFFFFF80. LBU at the same address → load_data=0x00000080.
- SH at 0x2002, wdata 0x0000ABCD, immediate ack → mem_we=1, be=1100, mem_wdata=0xABCDABCD, done at N+2.
- LW at 0x1001 → fault at N+1 with cause 01; mem_req never asserts. funct3=011 at any address → cause 10.
- With TIMEOUT=4 and mem_ack held low → mem_req high for exactly 4 cycles, then fault with cause 11; a late ack in IDLE has no effect.
- rst_n pulsed low during ACCESS → mem_req and stall drop at once with no done or fault; the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes, FSM states,
// and fault causes.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} lsu_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: request legality, byte enables, store lane
// replication, and load byte/half extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    output logic            illegal,
    output logic            misalign,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_lanes,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_ext
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        if (store)
            illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
        else
            illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});

        // funct3[1:0] encodes size for both loads and stores
        case (funct3[1:0])
            2'b00: begin
                misalign    = 1'b0;
                be          = 4'b0001 << off;
                wdata_lanes = {(XLEN/8){wdata[7:0]}};
            end
            2'b01: begin
                misalign    = off[0];
                be          = 4'b0011 << off;
                wdata_lanes = {(XLEN/16){wdata[15:0]}};
            end
            default: begin
                misalign    = |off;
                be          = 4'b1111;
                wdata_lanes = wdata;
            end
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_LB:   load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/ack data-memory transaction per
// request, pipeline stall while busy, fault reporting with a bounded wait.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ls_valid,
    input  logic            ls_store,
    input  logic [2:0]      ls_funct3,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            fault,
    output logic [1:0]      fault_cause,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            illegal, misalign;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_lanes, load_ext;

    lsu_align #(.XLEN(XLEN)) u_align (
        .store       (ls_store),
        .funct3      (ls_funct3),
        .off         (ls_addr[1:0]),
        .wdata       (ls_wdata),
        .illegal     (illegal),
        .misalign    (misalign),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .ld_funct3   (f3_q),
        .ld_off      (off_q),
        .rdata       (mem_rdata),
        .load_ext    (load_ext)
    );

    // Gated by rst_n so the upstream freeze releases the instant reset hits.
    assign stall = rst_n & ((state == IDLE & ls_valid) | (state == ACCESS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            done        <= 1'b0;
            load_data   <= '0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: if (ls_valid) begin
                    mem_addr  <= {ls_addr[XLEN-1:2], 2'b00};
                    mem_we    <= ls_store;
                    mem_be    <= be;
                    mem_wdata <= wdata_lanes;
                    f3_q      <= ls_funct3;
                    off_q     <= ls_addr[1:0];
                    if (illegal) begin
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_ILLEGAL;
                        state       <= FAULT;
                    end else if (misalign) begin
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_MISALIGN;
                        state       <= FAULT;
                    end else begin
                        mem_req <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        done      <= 1'b1;
                        load_data <= load_ext;
                        cnt       <= '0;
                        state     <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req     <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        cnt         <= '0;
                        state       <= FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    fault       <= 1'b0;
                    fault_cause <= CAUSE_NONE;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_store;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic        stall, done, fault;
    logic [31:0] load_data;
    logic [1:0]  fault_cause;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    int          lat, nreq;
    logic [31:0] ld, ad, wdo;
    logic [3:0]  be;
    logic        we, dn, flt, sok;
    logic [1:0]  cs;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ls_valid(ls_valid), .ls_store(ls_store), .ls_funct3(ls_funct3),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .stall(stall), .done(done), .load_data(load_data),
        .fault(fault), .fault_cause(fault_cause),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one request and records what the DUT did; ack is raised in the
    // (dly+1)-th mem_req cycle. lat counts edges from accept to done/fault.
    task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly,
                        output int o_lat, output int o_nreq, output logic [31:0] o_ld,
                        output logic [31:0] o_ad, output logic [31:0] o_wdo,
                        output logic [3:0] o_be, output logic o_we, output logic o_dn,
                        output logic o_flt, output logic [1:0] o_cs, output logic o_sok);
        o_lat = 0; o_nreq = 0; o_ld = '0; o_ad = '0; o_wdo = '0; o_be = '0;
        o_we = 1'b0; o_dn = 1'b0; o_flt = 1'b0; o_cs = '0;
        ls_store = st; ls_funct3 = f3; ls_addr = a; ls_wdata = wd;
        mem_rdata = rd; mem_ack = 1'b0; ls_valid = 1'b1;
        #1 o_sok = (stall === 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            o_lat++;
            mem_ack = 1'b0;
            if (done || fault) begin
                o_dn  = done;
                o_flt = fault;
                o_cs  = fault_cause;
                o_ld  = load_data;
                o_sok = o_sok & (stall === 1'b0) & !mem_req;
                break;
            end
            o_sok = o_sok & (stall === 1'b1);
            if (mem_req) begin
                o_nreq++;
                o_ad  = mem_addr;
                o_wdo = mem_wdata;
                o_be  = mem_be;
                o_we  = mem_we;
                if (o_nreq == dly + 1) mem_ack = 1'b1;
            end
        end
        ls_valid = 1'b0;
        mem_ack  = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ls_valid = 1'b0; ls_store = 1'b0; ls_funct3 = '0;
        ls_addr = '0; ls_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        chk("rst stall",   32'(stall), 0);
        chk("rst done",    32'(done), 0);
        chk("rst fault",   32'(fault), 0);
        chk("rst cause",   32'(fault_cause), 0);
        chk("rst req",     32'(mem_req), 0);
        chk("rst we",      32'(mem_we), 0);
        chk("rst addr",    mem_addr, 0);
        chk("rst be",      32'(mem_be), 0);
        chk("rst wdata",   mem_wdata, 0);
        chk("rst ldata",   load_data, 0);
        rst_n = 1'b1;
        step();

        xact(1'b0, 3'b010, 32'h1000, 0, 32'hDEADBEEF, 1, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("lw done",  32'(dn), 1);
        chk("lw lat",   lat, 3);
        chk("lw data",  ld, 32'hDEADBEEF);
        chk("lw be",    32'(be), 32'hF);
        chk("lw addr",  ad, 32'h1000);
        chk("lw we",    32'(we), 0);
        chk("lw stall", 32'(sok), 1);

        xact(1'b0, 3'b000, 32'h1003, 0, 32'h80FFFFFF, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("lb lat",   lat, 2);
        chk("lb be",    32'(be), 32'h8);
        chk("lb addr",  ad, 32'h1000);
        chk("lb data",  ld, 32'hFFFFFF80);

        xact(1'b0, 3'b100, 32'h1003, 0, 32'h80FFFFFF, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("lbu data", ld, 32'h00000080);

        xact(1'b0, 3'b001, 32'h1002, 0, 32'h80011234, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("lh be",    32'(be), 32'hC);
        chk("lh data",  ld, 32'hFFFF8001);

        xact(1'b0, 3'b101, 32'h1000, 0, 32'h1234F00F, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("lhu data", ld, 32'h0000F00F);

        xact(1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 0, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("sh done",  32'(dn), 1);
        chk("sh lat",   lat, 2);
        chk("sh we",    32'(we), 1);
        chk("sh be",    32'(be), 32'hC);
        chk("sh wdata", wdo, 32'hABCDABCD);
        chk("sh addr",  ad, 32'h2000);

        xact(1'b1, 3'b000, 32'h1001, 32'h12345678, 0, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("sb be",    32'(be), 32'h2);
        chk("sb wdata", wdo, 32'h78787878);

        xact(1'b0, 3'b010, 32'h1001, 0, 0, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("mis fault", 32'(flt), 1);
        chk("mis cause", 32'(cs), 1);
        chk("mis lat",   lat, 1);
        chk("mis nreq",  nreq, 0);
        chk("mis stall", 32'(sok), 1);

        xact(1'b0, 3'b011, 32'h1000, 0, 0, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("ill ld cause", 32'(cs), 2);
        chk("ill ld nreq",  nreq, 0);

        xact(1'b1, 3'b100, 32'h1000, 0, 0, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("ill st cause", 32'(cs), 2);

        xact(1'b0, 3'b111, 32'h1001, 0, 0, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("ill prio cause", 32'(cs), 2);

        xact(1'b1, 3'b001, 32'h1001, 0, 0, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("sh mis cause", 32'(cs), 1);

        xact(1'b0, 3'b010, 32'h3000, 0, 0, 99, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("to nreq",  nreq, 4);
        chk("to fault", 32'(flt), 1);
        chk("to cause", 32'(cs), 3);
        chk("to lat",   lat, 5);
        chk("to done",  32'(dn), 0);

        mem_ack = 1'b1;
        step();
        chk("late ack done",  32'(done), 0);
        chk("late ack req",   32'(mem_req), 0);
        chk("late ack fault", 32'(fault), 0);
        mem_ack = 1'b0;
        step();

        ls_store = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h4000; ls_valid = 1'b1;
        step();
        chk("mid req",   32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst req",   32'(mem_req), 0);
        chk("mid rst stall", 32'(stall), 0);
        step();
        chk("mid rst done",  32'(done), 0);
        chk("mid rst fault", 32'(fault), 0);
        ls_valid = 1'b0;
        rst_n = 1'b1;
        step();

        xact(1'b0, 3'b010, 32'h1004, 0, 32'h01234567, 0, lat, nreq, ld, ad, wdo, be, we, dn, flt, cs, sok);
        chk("post rst done", 32'(dn), 1);
        chk("post rst lat",  lat, 2);
        chk("post rst data", ld, 32'h01234567);
        chk("post rst addr", ad, 32'h1004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
